// File: rtl/ld_st_issue_age_ctrl_pkg.sv
// Shared types for the load/store issue queue control.
// ld_st_age_list_t is the default-depth packed view of the age list
// (oldest slot at order[0]) plus its live-entry count.
package ld_st_issue_age_ctrl_pkg;

  localparam int LDQ_DEPTH_DFLT = 4;
  localparam int LDQ_IDX_W_DFLT = $clog2(LDQ_DEPTH_DFLT);

  typedef struct packed {
    logic [LDQ_DEPTH_DFLT-1:0][LDQ_IDX_W_DFLT-1:0] order;
    logic [LDQ_IDX_W_DFLT:0]                       count;
  } ld_st_age_list_t;

endpackage

// File: rtl/ld_st_oldest_ready_pick.sv
// Combinational oldest-ready picker over an age-ordered slot list.
// Only the first i_count entries of i_order are live; order[0] is oldest.
// Shared with the ALU queue's age-ordered variant.
module ld_st_oldest_ready_pick
  import ld_st_issue_age_ctrl_pkg::*;
#(
  parameter int DEPTH = LDQ_DEPTH_DFLT,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0][IDX_W-1:0] i_order,
  input  logic [IDX_W:0]              i_count,
  input  logic [DEPTH-1:0]            i_ready_bits,
  output logic                        o_valid,
  output logic [IDX_W-1:0]            o_idx
);

  // Scan youngest to oldest so the oldest ready live entry wins last.
  always_comb begin
    // NOTE: every output gets a default before the loop, so no latch can form.
    o_valid = 1'b0;
    o_idx   = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (((IDX_W + 1)'(k) < i_count) && i_ready_bits[i_order[k]]) begin
        o_valid = 1'b1;
        o_idx   = i_order[k];
      end
    end
  end

endmodule

// File: rtl/ld_st_issue_age_ctrl.sv
// Control end of the load/store issue queue: slot allocation, age-ordered
// oldest-ready selection with a held valid/ready offer, and age list upkeep.
// Optional build macro LDST_IN_ORDER_ISSUE_EN restricts selection to the
// oldest live entry so memory ops issue strictly in program order.
module ld_st_issue_age_ctrl
  import ld_st_issue_age_ctrl_pkg::*;
#(
  parameter int QUEUE_DEPTH = LDQ_DEPTH_DFLT
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             dispatch_valid,
  output logic                             dispatch_ready,
  output logic                             rs_station_wen,
  output logic [$clog2(QUEUE_DEPTH)-1:0]   rs_station_waddr,
  input  logic [QUEUE_DEPTH-1:0]           rs_queue_valid_bits,
  input  logic [QUEUE_DEPTH-1:0]           incoming_valid_bits,
  input  logic [QUEUE_DEPTH-1:0]           rs_ready_bits,
  output logic                             issue_valid,
  input  logic                             issue_ready,
  output logic                             rs_station_complete,
  output logic [$clog2(QUEUE_DEPTH)-1:0]   rs_station_raddr,
  output logic [$clog2(QUEUE_DEPTH):0]     occupancy
);

  localparam int LDQ_IDX_W = $clog2(QUEUE_DEPTH);
  localparam int CNT_W     = LDQ_IDX_W + 1;

  logic [QUEUE_DEPTH-1:0][LDQ_IDX_W-1:0] r_order;
  logic [CNT_W-1:0]                      r_count;
  logic                                  r_lock_vld;
  logic [LDQ_IDX_W-1:0]                  r_lock_idx;

  logic                                  w_full;
  logic [LDQ_IDX_W-1:0]                  w_free_idx;
  logic                                  w_wen;
  logic [CNT_W-1:0]                      w_pick_cnt;
  logic                                  w_pick_vld;
  logic [LDQ_IDX_W-1:0]                  w_pick_idx;
  logic                                  w_issue_valid;
  logic [LDQ_IDX_W-1:0]                  w_sel;
  logic [QUEUE_DEPTH-1:0][LDQ_IDX_W-1:0] w_nxt_order;
  logic [CNT_W-1:0]                      w_nxt_count;

  // Lowest free slot receives the next dispatch.
  always_comb begin
    w_free_idx = '0;
    for (int i = QUEUE_DEPTH - 1; i >= 0; i--) begin
      if (!rs_queue_valid_bits[i]) w_free_idx = LDQ_IDX_W'(i);
    end
  end

  assign w_full           = &rs_queue_valid_bits;
  assign w_wen            = rst_n && dispatch_valid && !w_full;
  assign dispatch_ready   = !rst_n || !w_full;
  assign rs_station_wen   = w_wen;
  assign rs_station_waddr = (rst_n && !w_full) ? w_free_idx : '0;

`ifdef LDST_IN_ORDER_ISSUE_EN
  // Only the oldest live entry may be picked.
  assign w_pick_cnt = (r_count != '0) ? CNT_W'(1) : '0;
`else
  assign w_pick_cnt = r_count;
`endif

  ld_st_oldest_ready_pick #(
    .DEPTH (QUEUE_DEPTH),
    .IDX_W (LDQ_IDX_W)
  ) u_pick (
    .i_order      (r_order),
    .i_count      (w_pick_cnt),
    .i_ready_bits (rs_ready_bits),
    .o_valid      (w_pick_vld),
    .o_idx        (w_pick_idx)
  );

  // A held offer keeps its slot; it drops if the slot is squashed or unready.
  always_comb begin
    if (r_lock_vld) begin
      w_sel         = r_lock_idx;
      w_issue_valid = rs_queue_valid_bits[r_lock_idx] && rs_ready_bits[r_lock_idx];
    end else begin
      w_sel         = w_pick_idx;
      w_issue_valid = w_pick_vld;
    end
  end

  assign issue_valid         = w_issue_valid;
  assign rs_station_raddr    = w_issue_valid ? w_sel : '0;
  assign rs_station_complete = w_issue_valid && issue_ready;
  assign occupancy           = r_count;

  // Next age list: survivors in order, then the new dispatch at the tail.
  always_comb begin
    logic [CNT_W-1:0] n;
    w_nxt_order = '0;
    n           = '0;
    for (int k = 0; k < QUEUE_DEPTH; k++) begin
      if ((CNT_W'(k) < r_count) && incoming_valid_bits[r_order[k]]) begin
        w_nxt_order[n[LDQ_IDX_W-1:0]] = r_order[k];
        n = n + CNT_W'(1);
      end
    end
    if (w_wen && incoming_valid_bits[w_free_idx] && (n < CNT_W'(QUEUE_DEPTH))) begin
      w_nxt_order[n[LDQ_IDX_W-1:0]] = w_free_idx;
      n = n + CNT_W'(1);
    end
    w_nxt_count = n;
  end

  // Register the age list and the held-offer lock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the age list is a handful of flops, so it is reset with the rest.
      r_order    <= '0;
      r_count    <= '0;
      r_lock_vld <= 1'b0;
      r_lock_idx <= '0;
    end else begin
      // NOTE: non-blocking here so every register samples pre-edge values.
      r_order    <= w_nxt_order;
      r_count    <= w_nxt_count;
      r_lock_vld <= w_issue_valid && !issue_ready;
      r_lock_idx <= w_sel;
    end
  end

  // Age list length must mirror the queue's live entries.
  a_count_matches_valid: assert property (@(posedge clk) disable iff (!rst_n)
    r_count == CNT_W'($countones(rs_queue_valid_bits)));

endmodule
